// File: rtl/conv_pkg.sv
// conv_pkg: FSM state type and arithmetic helpers for convolution_filter.
// Optional macro CONV_ABS_RESULT_EN: rectify the shifted sum (edge magnitude).
package conv_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Signed MAC width that cannot overflow for kh*kw taps.
  function automatic int acc_width(
    input int w,
    input int kh,
    input int kw
  );
    return 2*w + $clog2(kh*kw) + 1;
  endfunction

  // Arithmetic shift by w_frac, then clamp to [0, 2^w-1].
  function automatic logic [63:0] sat_shift(
    input logic signed [63:0] acc,
    input int                 w_frac,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] mx;
    s  = acc >>> w_frac;
`ifdef CONV_ABS_RESULT_EN
    if (s < 0) s = -s;
`endif
    mx = (64'sd1 <<< w) - 64'sd1;
    if (s < 0) return '0;
    if (s > mx) return mx;
    return s;
  endfunction

endpackage

// File: rtl/convolution_filter_if.sv
// convolution_filter_if: input (x) and output (y) valid/ready streams.
// master = pixel source/sink side, slave = filter side.
interface convolution_filter_if #(
  parameter int W = 8
);
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] x_data;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] y_data;

  modport master (
    output x_valid, x_data, y_ready,
    input  x_ready, y_valid, y_data
  );

  modport slave (
    input  x_valid, x_data, y_ready,
    output x_ready, y_valid, y_data
  );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-entry delay line, one read+write slot per step.
// Ports: clk, rst, en (advance), din, dout (value written DEPTH steps ago).
module conv_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Contents need no reset: stale taps are masked by position.
  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

  assign dout = mem_q[ptr_q];
endmodule

// File: rtl/convolution_filter.sv
// convolution_filter: streaming zero-padded 2-D convolution, 1 out per pixel.
// Ports: clk, rst (async high), bus (x/y valid-ready streams), kernel coeffs.
module convolution_filter
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KERNEL_H   = 3,
  parameter int KERNEL_W   = 3,
  parameter int W          = 8,
  parameter int W_FRAC     = 0
) (
  input logic                clk,
  input logic                rst,
  convolution_filter_if.slave bus,
  input logic signed [W-1:0] kernel [KERNEL_H][KERNEL_W]
);
  localparam int N   = IMG_WIDTH * IMG_HEIGHT;
  localparam int D   = (KERNEL_H/2)*IMG_WIDTH + KERNEL_W/2;
  localparam int AW  = acc_width(W, KERNEL_H, KERNEL_W);
  localparam int CW  = $clog2(N + 1);
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CLW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [RW-1:0]   out_r_q, out_r_d;
  logic [CLW-1:0]  out_c_q, out_c_d;
  logic            y_valid_q, y_valid_d;
  logic [W-1:0]    y_data_q, y_data_d;
  logic [W-1:0]    win_q [KERNEL_H][KERNEL_W];
  logic [W-1:0]    win_d [KERNEL_H][KERNEL_W];
  logic [W-1:0]    col [KERNEL_H];

  logic            can_take, x_rdy, fire;
  logic            flush_step, step, produce;
  logic            last_in, last_out;
  logic [W-1:0]    px, tap, y_sat;
  logic signed [AW-1:0] acc;
  int              tr, tc;

  // Row KERNEL_H-1 is the newest line; each buffer delays one line more.
  assign col[KERNEL_H-1] = px;

  for (genvar m = 0; m < KERNEL_H-1; m++) begin : g_lb
    conv_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .W     (W)
    ) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (step),
      .din  (col[KERNEL_H-1-m]),
      .dout (col[KERNEL_H-2-m])
    );
  end

  always_comb begin
    can_take   = !y_valid_q || bus.y_ready;
    x_rdy      = !rst && can_take &&
                 ((state_q == FILL) || (state_q == RUN));
    fire       = bus.x_valid && x_rdy;
    flush_step = (state_q == FLUSH) && can_take;
    step       = fire || flush_step;
    // Flush feeds zeros; the buffers still supply the rows above.
    px         = fire ? bus.x_data : '0;
  end

  always_comb begin
    win_d = win_q;
    if (step) begin
      for (int i = 0; i < KERNEL_H; i++) begin
        for (int j = 0; j < KERNEL_W-1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][KERNEL_W-1] = col[i];
      end
    end
  end

  // MAC over the shifted window, masking taps outside the image.
  always_comb begin
    acc = '0;
    tr  = 0;
    tc  = 0;
    tap = '0;
    for (int i = 0; i < KERNEL_H; i++) begin
      for (int j = 0; j < KERNEL_W; j++) begin
        tr  = int'(out_r_q) + i - KERNEL_H/2;
        tc  = int'(out_c_q) + j - KERNEL_W/2;
        tap = (tr >= 0 && tr < IMG_HEIGHT &&
               tc >= 0 && tc < IMG_WIDTH) ? win_d[i][j] : '0;
        acc = acc + AW'(signed'({1'b0, tap})) * AW'(kernel[i][j]);
      end
    end
    y_sat = W'(sat_shift(64'(acc), W_FRAC, W));
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_r_d   = out_r_q;
    out_c_d   = out_c_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;

    produce  = flush_step || (fire && (in_cnt_q >= CW'(D)));
    last_in  = (in_cnt_q == CW'(N-1));
    last_out = (out_r_q == RW'(IMG_HEIGHT-1)) &&
               (out_c_q == CLW'(IMG_WIDTH-1));

    if (fire) begin
      in_cnt_d = last_in ? '0 : in_cnt_q + CW'(1);
    end

    if (produce) begin
      y_valid_d = 1'b1;
      y_data_d  = y_sat;
      if (out_c_q == CLW'(IMG_WIDTH-1)) begin
        out_c_d = '0;
        out_r_d = last_out ? '0 : out_r_q + RW'(1);
      end else begin
        out_c_d = out_c_q + CLW'(1);
      end
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end

    unique case (state_q)
      FILL, RUN: begin
        if (fire) begin
          if (last_in) state_d = (produce && last_out) ? FILL : FLUSH;
          else if (produce) state_d = RUN;
        end
      end
      FLUSH: begin
        if (flush_step && last_out) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      in_cnt_q  <= '0;
      out_r_q   <= '0;
      out_c_q   <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_r_q   <= out_r_d;
      out_c_q   <= out_c_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign bus.x_ready = x_rdy;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
endmodule

// File: tb/tb_convolution_filter.sv
// tb_convolution_filter: directed checks of convolution_filter on 8x6 frames.
// Two instances: W_FRAC=0 (main) and W_FRAC=3 (fractional scaling).
module tb_convolution_filter;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int NP = IW * IH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  convolution_filter_if #(.W(8)) bus0 ();
  convolution_filter_if #(.W(8)) bus1 ();

  logic signed [7:0] kern0 [3][3];
  logic signed [7:0] kern1 [3][3];

  convolution_filter #(
    .IMG_WIDTH (IW), .IMG_HEIGHT (IH),
    .KERNEL_H (3), .KERNEL_W (3), .W (8), .W_FRAC (0)
  ) dut0 (
    .clk (clk), .rst (rst), .bus (bus0), .kernel (kern0)
  );

  convolution_filter #(
    .IMG_WIDTH (IW), .IMG_HEIGHT (IH),
    .KERNEL_H (3), .KERNEL_W (3), .W (8), .W_FRAC (3)
  ) dut1 (
    .clk (clk), .rst (rst), .bus (bus1), .kernel (kern1)
  );

  int img [2*NP];
  int got [2*NP];
  int ref0 [NP];
  int n_chk = 0;
  int n_fail = 0;
  int n_unstable = 0;
  int first_sent = -1;

  task automatic chk(input string tag, input int idx,
                     input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d",
             tag, idx, obs, exp);
    end
  endtask

  task automatic set_k(input int k [9]);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        kern0[i][j] = 8'(k[i*3+j]);
  endtask

  // Reference: direct zero-padded convolution of frame f at index k.
  function automatic int model(input int f, input int k);
    int r, c, rr, cc, s;
    r = k / IW;
    c = k % IW;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        rr = r + i - 1;
        cc = c + j - 1;
        if (rr >= 0 && rr < IH && cc >= 0 && cc < IW)
          s += img[f*NP + rr*IW + cc] * int'(kern0[i][j]);
      end
`ifdef CONV_ABS_RESULT_EN
    if (s < 0) s = -s;
`endif
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic chk_frame(input string tag, input int f);
    for (int k = 0; k < NP; k++)
      chk(tag, k, got[f*NP + k], model(f, k));
  endtask

  // Streams nf frames from img[] and collects outputs into got[].
  task automatic run(input int nf, input int xv_pct, input int yr_pct);
    int total, sent, rcvd, cyc, hv, extra;
    bit held;
    total = nf * NP;
    sent = 0; rcvd = 0; cyc = 0; hv = 0; held = 0;
    first_sent = -1;
    while (rcvd < total && cyc < 4000) begin
      @(negedge clk);
      bus0.y_ready = ($urandom_range(99) < yr_pct);
      bus0.x_valid = (sent < total) && ($urandom_range(99) < xv_pct);
      bus0.x_data  = (sent < total) ? 8'(img[sent]) : 8'd0;
      #1;
      if (held && (!bus0.y_valid || int'(bus0.y_data) != hv))
        n_unstable++;
      if (bus0.y_valid && first_sent < 0) first_sent = sent;
      if (bus0.y_valid && bus0.y_ready) begin
        if (rcvd < 2*NP) got[rcvd] = int'(bus0.y_data);
        rcvd++;
        held = 0;
      end else if (bus0.y_valid) begin
        held = 1;
        hv = int'(bus0.y_data);
      end else begin
        held = 0;
      end
      if (bus0.x_valid && bus0.x_ready) sent++;
      cyc++;
    end
    chk("out_count", nf, rcvd, total);
    bus0.x_valid = 1'b0;
    bus0.y_ready = 1'b1;
    extra = 0;
    repeat (16) begin
      @(negedge clk);
      #1;
      if (bus0.y_valid) extra++;
    end
    chk("no_extra", nf, extra, 0);
  endtask

  initial begin
    int sent, cyc, rcv;
    bus0.x_valid = 1'b0; bus0.x_data = '0; bus0.y_ready = 1'b0;
    bus1.x_valid = 1'b0; bus1.x_data = '0; bus1.y_ready = 1'b0;
    set_k('{0, 0, 0, 0, 1, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        kern1[i][j] = 8'sd1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_x_ready", 0, int'(bus0.x_ready), 0);
    chk("rst_y_valid", 0, int'(bus0.y_valid), 0);
    chk("rst_y_data", 0, int'(bus0.y_data), 0);
    rst = 1'b0;

    // Identity kernel on a ramp: pass-through, first output after idx 9.
    for (int k = 0; k < NP; k++) img[k] = (k*3 + 1) & 255;
    run(1, 100, 100);
    chk("first_valid_sent", 0, first_sent, 10);
    for (int k = 0; k < NP; k++) chk("identity", k, got[k], img[k]);

    // All-ones on constant 10.
    set_k('{1, 1, 1, 1, 1, 1, 1, 1, 1});
    for (int k = 0; k < NP; k++) img[k] = 10;
    run(1, 100, 100);
    chk("ones_interior", 9, got[9], 90);
    chk("ones_edge_top", 1, got[1], 60);
    chk("ones_edge_left", 8, got[8], 60);
    chk("ones_corner_tl", 0, got[0], 40);
    chk("ones_corner_br", 47, got[47], 40);
    chk("ones_edge_right", 15, got[15], 60);

    // Edge kernel on constant 100.
    set_k('{-1, -1, -1, -1, 8, -1, -1, -1, -1});
    for (int k = 0; k < NP; k++) img[k] = 100;
    run(1, 100, 100);
    chk("edge_interior", 9, got[9], 0);
    chk("edge_edge", 1, got[1], 255);
    chk("edge_corner", 0, got[0], 255);

    // A dark pixel among 100s: sum -800.
    img[19] = 0;
    run(1, 100, 100);
`ifdef CONV_ABS_RESULT_EN
    chk("edge_dark_abs", 19, got[19], 255);
`else
    chk("edge_dark_clip", 19, got[19], 0);
`endif
    chk_frame("edge_dark", 0);

    // Asymmetric kernel, random image, full rate then stalled.
    set_k('{1, 2, 0, -1, 3, 1, 0, -2, 1});
    for (int k = 0; k < NP; k++) img[k] = int'($urandom_range(255));
    run(1, 100, 100);
    chk_frame("asym_full", 0);
    for (int k = 0; k < NP; k++) ref0[k] = got[k];
    run(1, 60, 50);
    for (int k = 0; k < NP; k++) chk("asym_stall", k, got[k], ref0[k]);
    chk("stall_stable", 0, n_unstable, 0);

    // Two frames back to back.
    for (int k = 0; k < NP; k++) img[k] = int'($urandom_range(255));
    for (int k = 0; k < NP; k++) img[NP + k] = (k*5) & 255;
    run(2, 100, 100);
    chk_frame("b2b_f0", 0);
    chk_frame("b2b_f1", 1);

    // Reset mid-frame after input 20.
    for (int k = 0; k < NP; k++) img[k] = (k*7 + 3) & 255;
    sent = 0;
    cyc = 0;
    while (sent < 21 && cyc < 200) begin
      @(negedge clk);
      bus0.x_valid = 1'b1;
      bus0.y_ready = 1'b1;
      bus0.x_data  = 8'(img[sent]);
      #1;
      if (bus0.x_valid && bus0.x_ready) sent++;
      cyc++;
    end
    chk("pre_rst_sent", 0, sent, 21);
    @(posedge clk);
    #2;
    chk("pre_rst_y_valid", 0, int'(bus0.y_valid), 1);
    bus0.x_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_y_valid", 0, int'(bus0.y_valid), 0);
    chk("mid_rst_x_ready", 0, int'(bus0.x_ready), 0);
    chk("mid_rst_y_data", 0, int'(bus0.y_data), 0);
    @(negedge clk);
    rst = 1'b0;
    run(1, 100, 100);
    chk_frame("post_rst", 0);

    // Fractional instance: all-ones on constant 16, >>3.
    rcv = 0;
    cyc = 0;
    bus1.y_ready = 1'b1;
    bus1.x_data  = 8'd16;
    while (rcv < NP && cyc < 1000) begin
      @(negedge clk);
      bus1.x_valid = 1'b1;
      #1;
      if (bus1.y_valid) begin
        got[rcv] = int'(bus1.y_data);
        rcv++;
      end
      cyc++;
    end
    bus1.x_valid = 1'b0;
    chk("frac_count", 0, rcv, NP);
    chk("frac_interior", 9, got[9], 18);
    chk("frac_edge", 1, got[1], 12);
    chk("frac_corner", 0, got[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
